// File: rtl/regfile_rename_pkg.sv
// Shared widths, types and constants for the renaming register file.
// Optional feature macro: REGFILE_BYPASS_EN (commit-to-read bypass in the read ports).
package regfile_rename_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int REG_WIDTH   = 5;
    localparam int TAG_WIDTH   = 4;
    localparam int NUM_REGS    = 1 << REG_WIDTH;
    localparam int COUNT_WIDTH = REG_WIDTH + 1;

    typedef logic [DATA_WIDTH-1:0]  data_t;
    typedef logic [REG_WIDTH-1:0]   reg_idx_t;
    typedef logic [TAG_WIDTH-1:0]   tag_t;
    typedef logic [COUNT_WIDTH-1:0] count_t;

    // MSB set with all other bits clear: the register value is final.
    localparam tag_t TAG_FREE = {1'b1, {(TAG_WIDTH-1){1'b0}}};

    // A register is busy while some in-flight ROB entry still owns it.
    function automatic logic tag_busy(input tag_t tag);
        return tag != TAG_FREE;
    endfunction

endpackage

// File: rtl/regfile_rename_reg_read_port.sv
// One decoder read port: selects stored data/tag, forces x0 to zero/free and,
// when REGFILE_BYPASS_EN is defined, forwards a same-cycle ROB commit.
module regfile_rename_reg_read_port
    import regfile_rename_pkg::*;
(
    input  logic [REG_WIDTH-1:0]  rd_name,
    input  logic [DATA_WIDTH-1:0] stored_data,
    input  logic [TAG_WIDTH-1:0]  stored_tag,
    input  logic                  commit_en,
    input  logic [REG_WIDTH-1:0]  commit_name,
    input  logic [DATA_WIDTH-1:0] commit_data,
    input  logic [TAG_WIDTH-1:0]  commit_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [TAG_WIDTH-1:0]  rd_tag
);

    // Read mux: stored state, optional commit bypass, x0 override last.
    always_comb begin
        // NOTE: outputs get defaults first so every path assigns them and no latch is inferred.
        rd_data = stored_data;
        rd_tag  = stored_tag;
`ifdef REGFILE_BYPASS_EN
        if (commit_en && (commit_name == rd_name)) begin
            rd_data = commit_data;
            // Only the owning producer frees the tag; a younger rename keeps it.
            if (stored_tag == commit_tag) begin
                rd_tag = TAG_FREE;
            end
        end
`endif
        if (rd_name == '0) begin
            rd_data = '0;
            rd_tag  = TAG_FREE;
        end
    end

`ifndef REGFILE_BYPASS_EN
    // Commit inputs only matter to the bypass path.
    logic unused_commit;
    assign unused_commit = ^{commit_en, commit_name, commit_data, commit_tag};
`endif

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags, sitting between
// the ROB commit port and the decoder operand fetch.
// Optional feature macro: REGFILE_BYPASS_EN (see regfile_rename_reg_read_port).
module regfile_rename
    import regfile_rename_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_WIDTH-1:0]   rs1_name,
    input  logic [REG_WIDTH-1:0]   rs2_name,
    output logic [DATA_WIDTH-1:0]  rs1_data,
    output logic [TAG_WIDTH-1:0]   rs1_tag,
    output logic [DATA_WIDTH-1:0]  rs2_data,
    output logic [TAG_WIDTH-1:0]   rs2_tag,
    input  logic                   rename_en,
    input  logic [REG_WIDTH-1:0]   rename_reg,
    input  logic [TAG_WIDTH-1:0]   rename_tag,
    input  logic                   regfileEnable,
    input  logic [REG_WIDTH-1:0]   rob_reg_name,
    input  logic [DATA_WIDTH-1:0]  rob_reg_data,
    input  logic [TAG_WIDTH-1:0]   rob_reg_tag,
    input  logic                   flush,
    output logic [REG_WIDTH:0]     busy_count
);

    data_t  regs_q [NUM_REGS];
    data_t  regs_d [NUM_REGS];
    tag_t   tags_q [NUM_REGS];
    tag_t   tags_d [NUM_REGS];
    count_t busy_count_q;
    count_t busy_count_d;

    // Next state: commit writes data and frees its own tag, then flush or rename sets tags.
    always_comb begin
        regs_d = regs_q;
        tags_d = tags_q;

        if (regfileEnable && (rob_reg_name != '0)) begin
            regs_d[rob_reg_name] = rob_reg_data;
            if (tags_q[rob_reg_name] == rob_reg_tag) begin
                tags_d[rob_reg_name] = TAG_FREE;
            end
        end

        // Flush drops every pending rename, including one issued this cycle;
        // otherwise a rename overrides a same-register commit's tag release.
        if (flush) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                tags_d[i] = TAG_FREE;
            end
        end else if (rename_en && (rename_reg != '0)) begin
            tags_d[rename_reg] = rename_tag;
        end

        // x0 is never renamed, so counting from x1 is exact.
        busy_count_d = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (tag_busy(tags_d[i])) begin
                busy_count_d = busy_count_d + count_t'(1);
            end
        end
    end

    // State update; synchronous reset overrides commit, rename and flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data array is reset on purpose: reads must return 0 after reset, so this is flops, not RAM.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
                tags_q[i] <= TAG_FREE;
            end
            busy_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
            regs_q       <= regs_d;
            tags_q       <= tags_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count = busy_count_q;

    regfile_rename_reg_read_port u_rs1_port (
        .rd_name     (rs1_name),
        .stored_data (regs_q[rs1_name]),
        .stored_tag  (tags_q[rs1_name]),
        .commit_en   (regfileEnable),
        .commit_name (rob_reg_name),
        .commit_data (rob_reg_data),
        .commit_tag  (rob_reg_tag),
        .rd_data     (rs1_data),
        .rd_tag      (rs1_tag)
    );

    regfile_rename_reg_read_port u_rs2_port (
        .rd_name     (rs2_name),
        .stored_data (regs_q[rs2_name]),
        .stored_tag  (tags_q[rs2_name]),
        .commit_en   (regfileEnable),
        .commit_name (rob_reg_name),
        .commit_data (rob_reg_data),
        .commit_tag  (rob_reg_tag),
        .rd_data     (rs2_data),
        .rd_tag      (rs2_tag)
    );

endmodule

// File: tb/tb_regfile_rename.sv
// Self-checking bench for regfile_rename: directed scenarios plus a randomized
// run against a behavioural model of the register/tag/busy-count rules.
module tb_regfile_rename;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int TW = 4;
    localparam int NR = 32;
    localparam logic [TW-1:0] FREE = 4'b1000;

    logic          clk;
    logic          rst;
    logic [RW-1:0] rs1_name, rs2_name;
    logic [DW-1:0] rs1_data, rs2_data;
    logic [TW-1:0] rs1_tag, rs2_tag;
    logic          rename_en;
    logic [RW-1:0] rename_reg;
    logic [TW-1:0] rename_tag;
    logic          regfileEnable;
    logic [RW-1:0] rob_reg_name;
    logic [DW-1:0] rob_reg_data;
    logic [TW-1:0] rob_reg_tag;
    logic          flush;
    logic [RW:0]   busy_count;

    int errors = 0;
    int checks = 0;

    // Behavioural model state.
    logic [DW-1:0] m_data [NR];
    logic [TW-1:0] m_tag  [NR];
    int            m_busy;

    regfile_rename dut (
        .clk           (clk),
        .rst           (rst),
        .rs1_name      (rs1_name),
        .rs2_name      (rs2_name),
        .rs1_data      (rs1_data),
        .rs1_tag       (rs1_tag),
        .rs2_data      (rs2_data),
        .rs2_tag       (rs2_tag),
        .rename_en     (rename_en),
        .rename_reg    (rename_reg),
        .rename_tag    (rename_tag),
        .regfileEnable (regfileEnable),
        .rob_reg_name  (rob_reg_name),
        .rob_reg_data  (rob_reg_data),
        .rob_reg_tag   (rob_reg_tag),
        .flush         (flush),
        .busy_count    (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rst = 1'b0; rename_en = 1'b0; rename_reg = '0; rename_tag = '0;
        regfileEnable = 1'b0; rob_reg_name = '0; rob_reg_data = '0; rob_reg_tag = '0;
        flush = 1'b0;
    endtask

    // Advance one clock and apply the same inputs to the model.
    task automatic tick();
        logic [TW-1:0] old_tag [NR];
        @(posedge clk);
        old_tag = m_tag;
        if (rst) begin
            for (int i = 0; i < NR; i++) begin m_data[i] = '0; m_tag[i] = FREE; end
            m_busy = 0;
        end else begin
            if (regfileEnable && rob_reg_name != 0) begin
                m_data[rob_reg_name] = rob_reg_data;
                if (old_tag[rob_reg_name] == rob_reg_tag) m_tag[rob_reg_name] = FREE;
            end
            if (flush) begin
                for (int i = 0; i < NR; i++) m_tag[i] = FREE;
            end else if (rename_en && rename_reg != 0) begin
                m_tag[rename_reg] = rename_tag;
            end
            for (int i = 0; i < NR; i++) begin
                if (old_tag[i] == FREE && m_tag[i] != FREE) m_busy++;
                else if (old_tag[i] != FREE && m_tag[i] == FREE) m_busy--;
            end
        end
        #1;
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [RW-1:0] n);
        if (n == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (regfileEnable && rob_reg_name == n) return rob_reg_data;
`endif
        return m_data[n];
    endfunction

    function automatic logic [TW-1:0] exp_tag(input logic [RW-1:0] n);
        if (n == 0) return FREE;
`ifdef REGFILE_BYPASS_EN
        if (regfileEnable && rob_reg_name == n) return (m_tag[n] == rob_reg_tag) ? FREE : m_tag[n];
`endif
        return m_tag[n];
    endfunction

    task automatic test_reset();
        idle(); rst = 1'b1; rs1_name = 5'd5; rs2_name = 5'd0;
        tick();
        rst = 1'b0; #1;
        checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", rs1_data, 32'h0); end
        checks++; if (rs1_tag !== FREE) begin errors++; $display("FAIL reset_tag: got %h expected %h", rs1_tag, FREE); end
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL reset_busy: got %0d expected 0", busy_count); end
    endtask

    task automatic test_commit_clears();
        idle(); rs1_name = 5'd5;
        rename_en = 1'b1; rename_reg = 5'd5; rename_tag = 4'd3; #1;
        checks++; if (rs1_tag !== FREE) begin errors++; $display("FAIL rename_not_visible_same_cycle: got %h expected %h", rs1_tag, FREE); end
        tick();
        checks++; if (rs1_tag !== 4'd3) begin errors++; $display("FAIL rename_tag: got %h expected %h", rs1_tag, 4'd3); end
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL rename_busy: got %0d expected 1", busy_count); end
        idle(); regfileEnable = 1'b1; rob_reg_name = 5'd5; rob_reg_tag = 4'd3; rob_reg_data = 32'hDEADBEEF;
        tick(); idle(); #1;
        checks++; if (rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL commit_data: got %h expected %h", rs1_data, 32'hDEADBEEF); end
        checks++; if (rs1_tag !== FREE) begin errors++; $display("FAIL commit_tag_freed: got %h expected %h", rs1_tag, FREE); end
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL commit_busy: got %0d expected 0", busy_count); end
    endtask

    task automatic test_younger_rename();
        idle(); rs1_name = 5'd5;
        rename_en = 1'b1; rename_reg = 5'd5; rename_tag = 4'd3; tick();
        rename_tag = 4'd6; tick();
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL rerename_busy: got %0d expected 1", busy_count); end
        idle(); regfileEnable = 1'b1; rob_reg_name = 5'd5; rob_reg_tag = 4'd3; rob_reg_data = 32'h11;
        tick(); idle(); #1;
        checks++; if (rs1_data !== 32'h11) begin errors++; $display("FAIL stale_commit_data: got %h expected %h", rs1_data, 32'h11); end
        checks++; if (rs1_tag !== 4'd6) begin errors++; $display("FAIL stale_commit_tag_kept: got %h expected %h", rs1_tag, 4'd6); end
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL stale_commit_busy: got %0d expected 1", busy_count); end
    endtask

    task automatic test_same_cycle();
        idle(); flush = 1'b1; tick();
        idle(); rs2_name = 5'd7;
        rename_en = 1'b1; rename_reg = 5'd7; rename_tag = 4'd2; tick();
        regfileEnable = 1'b1; rob_reg_name = 5'd7; rob_reg_tag = 4'd2; rob_reg_data = 32'h55;
        rename_tag = 4'd4; tick(); idle(); #1;
        checks++; if (rs2_data !== 32'h55) begin errors++; $display("FAIL same_cycle_data: got %h expected %h", rs2_data, 32'h55); end
        checks++; if (rs2_tag !== 4'd4) begin errors++; $display("FAIL same_cycle_tag: got %h expected %h", rs2_tag, 4'd4); end
        checks++; if (busy_count !== 6'd1) begin errors++; $display("FAIL same_cycle_busy: got %0d expected 1", busy_count); end
    endtask

    task automatic test_flush();
        idle(); rename_en = 1'b1;
        rename_reg = 5'd1; rename_tag = 4'd1; tick();
        rename_reg = 5'd2; rename_tag = 4'd2; tick();
        rename_reg = 5'd3; rename_tag = 4'd3; tick();
        checks++; if (busy_count !== 6'd4) begin errors++; $display("FAIL preflush_busy: got %0d expected 4", busy_count); end
        flush = 1'b1; rename_reg = 5'd4; rename_tag = 4'd5;
        regfileEnable = 1'b1; rob_reg_name = 5'd1; rob_reg_tag = 4'd7; rob_reg_data = 32'h9;
        tick(); idle();
        rs1_name = 5'd1; rs2_name = 5'd4; #1;
        checks++; if (rs1_data !== 32'h9) begin errors++; $display("FAIL flush_commit_data: got %h expected %h", rs1_data, 32'h9); end
        checks++; if (rs1_tag !== FREE) begin errors++; $display("FAIL flush_tag_x1: got %h expected %h", rs1_tag, FREE); end
        checks++; if (rs2_tag !== FREE) begin errors++; $display("FAIL flush_rename_dropped: got %h expected %h", rs2_tag, FREE); end
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL flush_busy: got %0d expected 0", busy_count); end
        rs1_name = 5'd2; rs2_name = 5'd3; #1;
        checks++; if (rs1_tag !== FREE || rs2_tag !== FREE) begin errors++; $display("FAIL flush_tags_x2_x3: got %h/%h expected %h", rs1_tag, rs2_tag, FREE); end
    endtask

    task automatic test_x0();
        idle(); rs1_name = 5'd0; rs2_name = 5'd0;
        rename_en = 1'b1; rename_reg = 5'd0; rename_tag = 4'd1; tick();
        idle(); regfileEnable = 1'b1; rob_reg_name = 5'd0; rob_reg_tag = 4'd1; rob_reg_data = 32'hFF;
        tick(); idle(); #1;
        checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_data: got %h expected %h", rs1_data, 32'h0); end
        checks++; if (rs2_tag !== FREE) begin errors++; $display("FAIL x0_tag: got %h expected %h", rs2_tag, FREE); end
        checks++; if (busy_count !== 6'd0) begin errors++; $display("FAIL x0_busy: got %0d expected 0", busy_count); end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] want;
        idle(); rs1_name = 5'd9;
        regfileEnable = 1'b1; rob_reg_name = 5'd9; rob_reg_tag = 4'd7; rob_reg_data = 32'h42; #1;
`ifdef REGFILE_BYPASS_EN
        want = 32'h42;
`else
        want = 32'h0;
`endif
        checks++; if (rs1_data !== want) begin errors++; $display("FAIL same_cycle_commit_read: got %h expected %h", rs1_data, want); end
        checks++; if (rs1_tag !== FREE) begin errors++; $display("FAIL same_cycle_commit_tag: got %h expected %h", rs1_tag, FREE); end
        tick(); idle(); #1;
        checks++; if (rs1_data !== 32'h42) begin errors++; $display("FAIL post_commit_read: got %h expected %h", rs1_data, 32'h42); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst           = ($urandom_range(0, 63) == 0);
            flush         = ($urandom_range(0, 15) == 0);
            rename_en     = $urandom_range(0, 1) == 1;
            rename_reg    = RW'($urandom_range(0, 7));
            rename_tag    = TW'($urandom_range(0, 7));
            regfileEnable = $urandom_range(0, 1) == 1;
            rob_reg_name  = RW'($urandom_range(0, 7));
            rob_reg_data  = $urandom;
            rob_reg_tag   = ($urandom_range(0, 1) == 1) ? m_tag[rob_reg_name] : TW'($urandom_range(0, 7));
            rs1_name      = RW'($urandom_range(0, 7));
            rs2_name      = RW'($urandom_range(0, 7));
            #1;
            checks++; if (rs1_data !== exp_data(rs1_name)) begin errors++; $display("FAIL rand_rs1_data c=%0d x%0d: got %h expected %h", c, rs1_name, rs1_data, exp_data(rs1_name)); end
            checks++; if (rs1_tag !== exp_tag(rs1_name)) begin errors++; $display("FAIL rand_rs1_tag c=%0d x%0d: got %h expected %h", c, rs1_name, rs1_tag, exp_tag(rs1_name)); end
            checks++; if (rs2_data !== exp_data(rs2_name)) begin errors++; $display("FAIL rand_rs2_data c=%0d x%0d: got %h expected %h", c, rs2_name, rs2_data, exp_data(rs2_name)); end
            checks++; if (rs2_tag !== exp_tag(rs2_name)) begin errors++; $display("FAIL rand_rs2_tag c=%0d x%0d: got %h expected %h", c, rs2_name, rs2_tag, exp_tag(rs2_name)); end
            checks++; if (busy_count !== 6'(m_busy)) begin errors++; $display("FAIL rand_busy c=%0d: got %0d expected %0d", c, busy_count, m_busy); end
            tick();
        end
        idle(); #1;
        checks++; if (busy_count !== 6'(m_busy)) begin errors++; $display("FAIL rand_busy_final: got %0d expected %0d", busy_count, m_busy); end
    endtask

    initial begin
        idle();
        rs1_name = '0;
        rs2_name = '0;
        test_reset();
        test_commit_clears();
        test_younger_rename();
        test_same_cycle();
        test_flush();
        test_x0();
        test_bypass();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
